// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with
//            run/step control, cycle/retire counters and trap handling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sequencer #(
  parameter int DBITS       = 32,
  parameter int OPBITS      = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int TOBITS      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPBITS-1:0] opcode,
  input  logic              cond_taken,
  input  logic              mem_ready,
  input  logic              run,
  input  logic              step,
  output logic              ir_wr_en,
  output logic              pc_wr_en,
  output logic [1:0]        pc_sel,
  output logic              reg_wr_en,
  output logic [1:0]        reg_src,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [2:0]        state,
  output logic              trap,
  output logic [1:0]        trap_code,
  output logic [DBITS-1:0]  cycle_count,
  output logic [DBITS-1:0]  instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] c_op_alur  = 4'b0000;
  localparam logic [3:0] c_op_alui  = 4'b1000;
  localparam logic [3:0] c_op_cmpr  = 4'b0010;
  localparam logic [3:0] c_op_cmpi  = 4'b1010;
  localparam logic [3:0] c_op_bcond = 4'b0110;
  localparam logic [3:0] c_op_sw    = 4'b0101;
  localparam logic [3:0] c_op_lw    = 4'b1001;
  localparam logic [3:0] c_op_jal   = 4'b1011;

  localparam logic [1:0] c_trap_illegal = 2'd1;
  localparam logic [1:0] c_trap_timeout = 2'd2;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_op;
  logic [TOBITS-1:0]   r_to;
  logic                r_trap;
  logic [1:0]          r_trap_code;
  logic [DBITS-1:0]    r_cycles;
  logic [DBITS-1:0]    r_instrs;

  logic [3:0]          w_pri;
  logic                w_legal;
  logic                w_timeout;
  logic                w_is_sw;
  logic                w_active;
  logic                w_set_trap;
  logic [1:0]          w_trap_code;
  logic                w_unused_opcode;

  assign w_pri           = opcode[OPBITS-1 -: 4];
  assign w_unused_opcode = &{1'b0, opcode[OPBITS-5:0]};
  assign w_timeout       = (r_to == TOBITS'(MEM_TIMEOUT));
  assign w_is_sw         = (r_op == c_op_sw);

  always_comb begin
    w_legal = 1'b0;
    case (w_pri)
      c_op_alur, c_op_alui, c_op_cmpr, c_op_cmpi,
      c_op_bcond, c_op_sw, c_op_lw, c_op_jal: w_legal = 1'b1;
      default:                                w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_active    = 1'b0;
    w_set_trap  = 1'b0;
    w_trap_code = 2'd0;
    ir_wr_en    = 1'b0;
    pc_wr_en    = 1'b0;
    pc_sel      = 2'd0;
    reg_wr_en   = 1'b0;
    reg_src     = 2'd0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;

    case (r_state)
      ST_FETCH: begin
        if (run || step) begin
          ir_wr_en = 1'b1;
          w_active = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_active = 1'b1;
        if (w_legal) begin
          w_next = ST_EXEC;
        end else begin
          w_next      = ST_TRAP;
          w_set_trap  = 1'b1;
          w_trap_code = c_trap_illegal;
        end
      end
      ST_EXEC: begin
        w_active = 1'b1;
        case (r_op)
          c_op_bcond: begin
            pc_wr_en = 1'b1;
            pc_sel   = cond_taken ? 2'd1 : 2'd0;
            w_next   = ST_FETCH;
          end
          c_op_sw, c_op_lw: w_next = ST_MEM;
          default:          w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        w_active = 1'b1;
        if (mem_ready) begin
          mem_wr_en = w_is_sw;
          mem_rd_en = !w_is_sw;
          pc_wr_en  = w_is_sw;
          w_next    = w_is_sw ? ST_FETCH : ST_WB;
        end else if (w_timeout) begin
          // Give up without issuing a request on the transition cycle.
          w_next      = ST_TRAP;
          w_set_trap  = 1'b1;
          w_trap_code = c_trap_timeout;
        end else begin
          mem_wr_en = w_is_sw;
          mem_rd_en = !w_is_sw;
        end
      end
      ST_WB: begin
        w_active  = 1'b1;
        reg_wr_en = 1'b1;
        pc_wr_en  = 1'b1;
        w_next    = ST_FETCH;
        if (r_op == c_op_lw) begin
          reg_src = 2'd1;
        end else if (r_op == c_op_jal) begin
          reg_src = 2'd2;
          pc_sel  = 2'd2;
        end
      end
      ST_TRAP: w_next = ST_TRAP;
      default: w_next = ST_FETCH;
    endcase

    // Enables must drop in the same instant reset rises, not at the next edge.
    if (reset) begin
      ir_wr_en  = 1'b0;
      pc_wr_en  = 1'b0;
      reg_wr_en = 1'b0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_op        <= 4'd0;
      r_to        <= '0;
      r_trap      <= 1'b0;
      r_trap_code <= 2'd0;
      r_cycles    <= '0;
      r_instrs    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_op <= w_pri;
      end
      if (r_state == ST_MEM && !mem_ready && w_next == ST_MEM) begin
        r_to <= r_to + 1'b1;
      end else begin
        r_to <= '0;
      end
      if (w_set_trap) begin
        r_trap      <= 1'b1;
        r_trap_code <= w_trap_code;
      end
      if (w_active) begin
        r_cycles <= r_cycles + 1'b1;
      end
      if (pc_wr_en) begin
        r_instrs <= r_instrs + 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign trap        = r_trap;
  assign trap_code   = r_trap_code;
  assign cycle_count = r_cycles;
  assign instr_count = r_instrs;

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the Project2 CPU datapath: PC, instruction register, RegFile, ALU, DMem/memory-mapped I/O.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Generates every datapath write enable and mux select, stalls on the DMem ready handshake, and supports run/single-step control.
- Provides cycle and retired-instruction counters and traps on illegal opcodes or memory timeouts.

Parameters:
- DBITS, 32, counter width.
- OPBITS, 8, opcode width (primary op = opcode[7:4]).
- MEM_TIMEOUT, 255, maximum cycles a MEM access waits for mem_ready before trapping.
- TOBITS, 8, width of the timeout counter; must satisfy 2^TOBITS > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  OPBITS  opcode field from decode, valid in DECODE.
- cond_taken  in  1  branch condition result from ALU flags, valid in EXEC.
- mem_ready  in  1  DMem/I/O access-complete handshake.
- run  in  1  level; 1 = free-run.
- step  in  1  one-cycle pulse; executes one instruction while run=0.
- ir_wr_en  out  1  instruction register load.
- pc_wr_en  out  1  PC load.
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = ALU result (JAL).
- reg_wr_en  out  1  RegFile write.
- reg_src  out  2  0 = ALU, 1 = DMem, 2 = PC+4.
- mem_rd_en  out  1  DMem read request.
- mem_wr_en  out  1  DMem write request.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- trap  out  1  sticky trap flag.
- trap_code  out  2  0 none, 1 illegal opcode, 2 memory timeout.
- cycle_count  out  DBITS  active cycles.
- instr_count  out  DBITS  retired instructions.

Behaviour:
- Reset (async): state=FETCH, op_q=0, timeout counter=0, trap=0, trap_code=0, both counters=0. All enables are 0 combinationally while reset=1; an in-flight MEM access is aborted and mem_wr_en drops in the same instant.
- Outputs decode from registered state/op_q, plus mem_ready and cond_taken (Mealy) where noted. Unlisted outputs are 0; pc_sel and reg_src are 0 unless stated.
- FETCH:
  - Advances only if run=1 or step=1 sampled at the edge.
  - When advancing: ir_wr_en=1, next state DECODE.
  - Otherwise it idles with all enables 0.
- DECODE:
  - op_q <= opcode[7:4].
  - Legal primary ops: ALUR 0000, ALUI 1000, CMPR 0010, CMPI 1010, BCOND 0110, SW 0101, LW 1001, JAL 1011.
  - Any other value -> TRAP with trap_code=1.
- EXEC by op_q:
  - ALU/CMP and JAL -> WB.
  - SW/LW -> MEM.
  - BCOND: pc_wr_en=1, pc_sel=cond_taken?1:0 (Mealy), instruction retires, next state FETCH.
- MEM:
  - SW holds mem_wr_en=1; LW holds mem_rd_en=1, until mem_ready=1.
  - Timeout counter increments each waiting cycle and clears on leaving MEM.
  - SW on the mem_ready cycle: pc_wr_en=1, pc_sel=0, retire, next state FETCH.
  - LW on the mem_ready cycle: next state WB.
  - If the counter reaches MEM_TIMEOUT with mem_ready=0: TRAP with trap_code=2. That transition cycle drives no write.
  - mem_ready outside MEM is ignored.
- WB: reg_wr_en=1, pc_wr_en=1, retire, next state FETCH. Selects by op:
  - ALU/CMP: reg_src=0, pc_sel=0.
  - LW: reg_src=1, pc_sel=0.
  - JAL: reg_src=2, pc_sel=2.
- Instruction latency: BCOND 3 cycles; ALU/CMP/JAL 4; SW 4+w; LW 5+w, where w = mem_ready wait cycles.
- TRAP: absorbing until reset. All enables 0; run and step are ignored.
- Counters:
  - cycle_count increments every cycle where state is not TRAP and not idling in FETCH.
  - instr_count increments on every retire (pc_wr_en=1).
  - Both wrap modulo 2^DBITS.
- Step/run interaction:
  - step while run=1 has no extra effect.
  - step arriving outside FETCH is ignored; it is not queued.
  - Deasserting run mid-instruction completes that instruction, then idles in FETCH.

Test Plan:
- Reset mid-run, then run=1 with opcode=0x00 (ALUR ADD): states 0,1,2,4,0. reg_wr_en and pc_wr_en high only in WB. instr_count=1 and cycle_count=4 after the first instruction.
- BCOND opcode=0x61: cond_taken=1 gives pc_sel=1 with pc_wr_en in EXEC; cond_taken=0 gives pc_sel=0. 3 cycles each; no reg_wr_en ever asserted.
- LW opcode=0x90 with mem_ready delayed 3 cycles: mem_rd_en high for 4 MEM cycles, then WB with reg_src=1. Total 8 cycles; instr_count +1.
- SW opcode=0x50 with mem_ready never asserted: mem_wr_en high for 255 cycles, then state=7, trap=1, trap_code=2, all enables 0. Counters freeze; reset clears everything.
- Illegal opcode 0x30 in DECODE: next state TRAP, trap_code=1, no pc_wr_en. run toggling has no effect.
- run=0 idling in FETCH: counters stay constant. One step pulse executes exactly one JAL (opcode 0xB0, WB with reg_src=2, pc_sel=2), then idles. step during EXEC is ignored.
